// File: rtl/e_mdu_ctrl_if.sv
// Execute-stage MDU bundle: op issue, operands, HI/LO state and hazard signals.
interface e_mdu_ctrl_if;
    logic        start;
    logic [2:0]  MDUOp;
    logic        rd_hi;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_mdu_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] mdu_rdata;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MDUOp, rd_hi, A, B, D_mdu_use,
        input  busy, stall_req, mdu_rdata, HI, LO
    );

    modport slave (
        input  start, MDUOp, rd_hi, A, B, D_mdu_use,
        output busy, stall_req, mdu_rdata, HI, LO
    );
endinterface

// File: rtl/e_mdu_ctrl.sv
// Multiply/divide unit for the E stage: owns HI/LO, models op latency with a
// down-counter and requests D-stage stalls for HI/LO hazards.
//
// state | meaning
// IDLE  | no op in flight; accepts mult/div/mt ops
// RUN   | op in flight; cnt counts down, result lands in HI/LO when cnt==1
module e_mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic         clk,
    input logic         reset,
    e_mdu_ctrl_if.slave mdu
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [31:0]        hi_q, lo_q, pend_hi, pend_lo;
    logic               pend_wr;

    logic               mul_signed, div_signed, neg_a, neg_b;
    logic [63:0]        ext_a, ext_b, prod;
    logic [31:0]        mag_a, mag_b, divisor, mag_q, mag_r, quo, rem;
    logic               op_long;

    // One 64-bit multiplier serves both flavours; sign extension selects mult vs multu.
    always_comb begin
        mul_signed = (mdu.MDUOp == 3'd1);
        ext_a      = {{32{mul_signed & mdu.A[31]}}, mdu.A};
        ext_b      = {{32{mul_signed & mdu.B[31]}}, mdu.B};
        prod       = ext_a * ext_b;
    end

    // Sign-magnitude divide keeps 0x80000000/-1 well defined (wraps to 0x80000000).
    always_comb begin
        div_signed = (mdu.MDUOp == 3'd3);
        neg_a      = div_signed & mdu.A[31];
        neg_b      = div_signed & mdu.B[31];
        mag_a      = neg_a ? (~mdu.A + 32'd1) : mdu.A;
        mag_b      = neg_b ? (~mdu.B + 32'd1) : mdu.B;
        divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
        mag_q      = mag_a / divisor;
        mag_r      = mag_a % divisor;
        quo        = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
        rem        = neg_a ? (~mag_r + 32'd1) : mag_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu.start) begin
                        case (mdu.MDUOp)
                            3'd1, 3'd2: begin
                                pend_hi <= prod[63:32];
                                pend_lo <= prod[31:0];
                                pend_wr <= 1'b1;
                                cnt     <= CNT_W'(MULT_LAT);
                                busy_q  <= 1'b1;
                                state   <= RUN;
                            end
                            3'd3, 3'd4: begin
                                pend_hi <= rem;
                                pend_lo <= quo;
                                pend_wr <= (mdu.B != 32'd0);
                                cnt     <= CNT_W'(DIV_LAT);
                                busy_q  <= 1'b1;
                                state   <= RUN;
                            end
                            3'd5:    hi_q <= mdu.A;
                            3'd6:    lo_q <= mdu.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign op_long       = (mdu.MDUOp >= 3'd1) && (mdu.MDUOp <= 3'd4);
    assign mdu.busy      = busy_q;
    assign mdu.stall_req = mdu.D_mdu_use & (busy_q | (mdu.start & op_long));
    assign mdu.mdu_rdata = mdu.rd_hi ? hi_q : lo_q;
    assign mdu.HI        = hi_q;
    assign mdu.LO        = lo_q;
endmodule
